// File: rtl/pe_pkg.sv
// Shared definitions for the background-removal processing element.
package pe_pkg;

    localparam int CHANNEL_W = 8;

    // One-hot encodings so each state bit is directly a registered flag.
    typedef enum logic [2:0] {
        SUM_INIT = 3'b001,
        SUM_BUSY = 3'b010,
        SUM_DONE = 3'b100
    } sum_state_t;

    typedef enum logic [2:0] {
        BG_INIT = 3'b001,
        BG_BUSY = 3'b010,
        BG_DONE = 3'b100
    } bg_state_t;

    // Width of a pixel index for a vector of n pixels.
    function automatic int pix_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Unsigned absolute difference of two channel values.
    function automatic logic [CHANNEL_W-1:0] abs_diff(input logic [CHANNEL_W-1:0] a,
                                                      input logic [CHANNEL_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pe_pixel_match.sv
// Combinational per-pixel background test: replaces a pixel whose every
// channel lies within threshold of the expected colour, otherwise passes it.
module pe_pixel_match
    import pe_pkg::*;
(
    input  logic [CHANNEL_W-1:0] pix_r,
    input  logic [CHANNEL_W-1:0] pix_g,
    input  logic [CHANNEL_W-1:0] pix_b,
    input  logic [CHANNEL_W-1:0] exp_r,
    input  logic [CHANNEL_W-1:0] exp_g,
    input  logic [CHANNEL_W-1:0] exp_b,
    input  logic [CHANNEL_W-1:0] threshold,
    input  logic [CHANNEL_W-1:0] des_r,
    input  logic [CHANNEL_W-1:0] des_g,
    input  logic [CHANNEL_W-1:0] des_b,
    output logic [CHANNEL_W-1:0] res_r,
    output logic [CHANNEL_W-1:0] res_g,
    output logic [CHANNEL_W-1:0] res_b
);

    logic is_bg;

    // Equality with the threshold still counts as background.
    always_comb begin
        is_bg = (abs_diff(pix_r, exp_r) <= threshold) &&
                (abs_diff(pix_g, exp_g) <= threshold) &&
                (abs_diff(pix_b, exp_b) <= threshold);
        if (is_bg) begin
            res_r = des_r;
            res_g = des_g;
            res_b = des_b;
        end else begin
            res_r = pix_r;
            res_g = pix_g;
            res_b = pix_b;
        end
    end

endmodule

// File: rtl/pe.sv
// Background-removal processing element: a sum phase that averages the
// pixel vector per channel, and a removal phase that swaps background-like
// pixels for a replacement colour. Each phase has its own one-hot FSM.
module pe
    import pe_pkg::*;
#(
    parameter int NUM_PIXELS = 4
) (
    input  logic                              Clk,
    input  logic                              Ack,
    input  logic                              Reset,
    input  logic [CHANNEL_W-1:0]              red_exp,
    input  logic [CHANNEL_W-1:0]              green_exp,
    input  logic [CHANNEL_W-1:0]              blue_exp,
    input  logic [CHANNEL_W-1:0]              threshold,
    input  logic [CHANNEL_W-1:0]              desired_bg_r,
    input  logic [CHANNEL_W-1:0]              desired_bg_g,
    input  logic [CHANNEL_W-1:0]              desired_bg_b,
    input  logic                              Start_Sum,
    input  logic                              Start_BgRemoval,
    input  logic [CHANNEL_W*NUM_PIXELS-1:0]   red_in,
    input  logic [CHANNEL_W*NUM_PIXELS-1:0]   green_in,
    input  logic [CHANNEL_W*NUM_PIXELS-1:0]   blue_in,
    output logic [CHANNEL_W*NUM_PIXELS-1:0]   red_out,
    output logic [CHANNEL_W*NUM_PIXELS-1:0]   green_out,
    output logic [CHANNEL_W*NUM_PIXELS-1:0]   blue_out,
    output logic                              Qi,
    output logic                              Qbgi,
    output logic                              Qbg,
    output logic                              Qbgd,
    output logic                              Qsi,
    output logic                              Qs,
    output logic                              Qsd,
    output logic [CHANNEL_W*NUM_PIXELS-1:0]   red_sum,
    output logic [CHANNEL_W*NUM_PIXELS-1:0]   green_sum,
    output logic [CHANNEL_W*NUM_PIXELS-1:0]   blue_sum
);

    localparam int IDX_W = pix_idx_w(NUM_PIXELS);
    localparam int ACC_W = CHANNEL_W + IDX_W;
    localparam int VEC_W = CHANNEL_W * NUM_PIXELS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    sum_state_t sum_state, sum_next;
    bg_state_t  bg_state, bg_next;

    logic [IDX_W-1:0] sum_idx, bg_idx;
    logic             sum_last, bg_last, bg_start;

    logic [ACC_W-1:0] acc_r, acc_g, acc_b;
    logic [ACC_W-1:0] acc_r_nxt, acc_g_nxt, acc_b_nxt;

    logic [CHANNEL_W-1:0] px_r  [NUM_PIXELS];
    logic [CHANNEL_W-1:0] px_g  [NUM_PIXELS];
    logic [CHANNEL_W-1:0] px_b  [NUM_PIXELS];
    logic [CHANNEL_W-1:0] out_r [NUM_PIXELS];
    logic [CHANNEL_W-1:0] out_g [NUM_PIXELS];
    logic [CHANNEL_W-1:0] out_b [NUM_PIXELS];
    logic [CHANNEL_W-1:0] res_r, res_g, res_b;

    // Unpack the input vectors and pack the output slots.
    always_comb begin
        for (int i = 0; i < NUM_PIXELS; i++) begin
            px_r[i] = red_in  [i*CHANNEL_W +: CHANNEL_W];
            px_g[i] = green_in[i*CHANNEL_W +: CHANNEL_W];
            px_b[i] = blue_in [i*CHANNEL_W +: CHANNEL_W];
            red_out  [i*CHANNEL_W +: CHANNEL_W] = out_r[i];
            green_out[i*CHANNEL_W +: CHANNEL_W] = out_g[i];
            blue_out [i*CHANNEL_W +: CHANNEL_W] = out_b[i];
        end
    end

    assign sum_last  = (sum_idx == LAST_IDX);
    assign bg_last   = (bg_idx == LAST_IDX);
    // A removal run may not begin while the average is still being built.
    assign bg_start  = Start_BgRemoval && (sum_state != SUM_BUSY);

    // Running totals including the pixel being added this clock, so the
    // final average can be registered on the same edge that enters done.
    assign acc_r_nxt = acc_r + ACC_W'(px_r[sum_idx]);
    assign acc_g_nxt = acc_g + ACC_W'(px_g[sum_idx]);
    assign acc_b_nxt = acc_b + ACC_W'(px_b[sum_idx]);

    // Sum FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) sum_state <= SUM_INIT;
        else       sum_state <= sum_next;
    end

    // Sum FSM next-state logic.
    always_comb begin
        sum_next = sum_state;
        case (sum_state)
            SUM_INIT: if (Start_Sum) sum_next = SUM_BUSY;
            SUM_BUSY: if (sum_last)  sum_next = SUM_DONE;
            SUM_DONE: if (Ack)       sum_next = SUM_INIT;
            default:                 sum_next = SUM_INIT;
        endcase
    end

    // Sum datapath: accumulate one pixel per clock, register the average on the last.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_r     <= '0;
            acc_g     <= '0;
            acc_b     <= '0;
            sum_idx   <= '0;
            red_sum   <= '0;
            green_sum <= '0;
            blue_sum  <= '0;
        end else begin
            case (sum_state)
                SUM_INIT: begin
                    if (Start_Sum) begin
                        acc_r   <= '0;
                        acc_g   <= '0;
                        acc_b   <= '0;
                        sum_idx <= '0;
                    end
                end
                SUM_BUSY: begin
                    acc_r   <= acc_r_nxt;
                    acc_g   <= acc_g_nxt;
                    acc_b   <= acc_b_nxt;
                    sum_idx <= sum_idx + 1'b1;
                    if (sum_last) begin
                        red_sum   <= {{(VEC_W-CHANNEL_W){1'b0}}, acc_r_nxt[ACC_W-1:IDX_W]};
                        green_sum <= {{(VEC_W-CHANNEL_W){1'b0}}, acc_g_nxt[ACC_W-1:IDX_W]};
                        blue_sum  <= {{(VEC_W-CHANNEL_W){1'b0}}, acc_b_nxt[ACC_W-1:IDX_W]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Bg FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) bg_state <= BG_INIT;
        else       bg_state <= bg_next;
    end

    // Bg FSM next-state logic.
    always_comb begin
        bg_next = bg_state;
        case (bg_state)
            BG_INIT: if (bg_start) bg_next = BG_BUSY;
            BG_BUSY: if (bg_last)  bg_next = BG_DONE;
            BG_DONE: if (Ack)      bg_next = BG_INIT;
            default:               bg_next = BG_INIT;
        endcase
    end

    pe_pixel_match u_match (
        .pix_r     (px_r[bg_idx]),
        .pix_g     (px_g[bg_idx]),
        .pix_b     (px_b[bg_idx]),
        .exp_r     (red_exp),
        .exp_g     (green_exp),
        .exp_b     (blue_exp),
        .threshold (threshold),
        .des_r     (desired_bg_r),
        .des_g     (desired_bg_g),
        .des_b     (desired_bg_b),
        .res_r     (res_r),
        .res_g     (res_g),
        .res_b     (res_b)
    );

    // Bg datapath: write one processed pixel per clock into its output slot.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bg_idx <= '0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                out_r[i] <= '0;
                out_g[i] <= '0;
                out_b[i] <= '0;
            end
        end else begin
            case (bg_state)
                BG_INIT: begin
                    if (bg_start) bg_idx <= '0;
                end
                BG_BUSY: begin
                    out_r[bg_idx] <= res_r;
                    out_g[bg_idx] <= res_g;
                    out_b[bg_idx] <= res_b;
                    bg_idx        <= bg_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Qsi  = (sum_state == SUM_INIT);
    assign Qs   = (sum_state == SUM_BUSY);
    assign Qsd  = (sum_state == SUM_DONE);
    assign Qbgi = (bg_state == BG_INIT);
    assign Qbg  = (bg_state == BG_BUSY);
    assign Qbgd = (bg_state == BG_DONE);
    assign Qi   = Qsi && Qbgi;

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: randomized and directed runs of both phases
// against a plain-arithmetic model of averaging and background replacement.
module tb_pe;

    localparam int N  = 4;
    localparam int VW = 8 * N;

    logic          Clk = 1'b0;
    logic          Ack, Reset;
    logic [7:0]    red_exp, green_exp, blue_exp, threshold;
    logic [7:0]    desired_bg_r, desired_bg_g, desired_bg_b;
    logic          Start_Sum, Start_BgRemoval;
    logic [VW-1:0] red_in, green_in, blue_in;
    logic [VW-1:0] red_out, green_out, blue_out;
    logic [VW-1:0] red_sum, green_sum, blue_sum;
    logic          Qi, Qbgi, Qbg, Qbgd, Qsi, Qs, Qsd;

    int checks = 0;
    int errors = 0;

    // Model state: what the outputs must show whenever no phase is in flight.
    logic          sum_busy = 1'b0;
    logic          bg_busy  = 1'b0;
    logic [VW-1:0] m_rs = '0, m_gs = '0, m_bs = '0;
    logic [VW-1:0] m_ro = '0, m_go = '0, m_bo = '0;
    logic [VW-1:0] p_rs, p_gs, p_bs, p_ro, p_go, p_bo;

    pe #(.NUM_PIXELS(N)) dut (
        .Clk(Clk), .Ack(Ack), .Reset(Reset),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
        .threshold(threshold),
        .desired_bg_r(desired_bg_r), .desired_bg_g(desired_bg_g), .desired_bg_b(desired_bg_b),
        .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .Qi(Qi), .Qbgi(Qbgi), .Qbg(Qbg), .Qbgd(Qbgd),
        .Qsi(Qsi), .Qs(Qs), .Qsd(Qsd),
        .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pix(input int i, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        red_in[i*8 +: 8]   = r;
        green_in[i*8 +: 8] = g;
        blue_in[i*8 +: 8]  = b;
    endtask

    // Average per channel: total of all pixels divided by the pixel count.
    task automatic model_sum();
        int sr, sg, sb;
        sr = 0; sg = 0; sb = 0;
        for (int i = 0; i < N; i++) begin
            sr += int'(red_in[i*8 +: 8]);
            sg += int'(green_in[i*8 +: 8]);
            sb += int'(blue_in[i*8 +: 8]);
        end
        p_rs = VW'(sr / N);
        p_gs = VW'(sg / N);
        p_bs = VW'(sb / N);
    endtask

    // Replacement: a pixel close enough on every channel becomes the desired colour.
    task automatic model_bg();
        int r, g, b, dr, dg, db;
        for (int i = 0; i < N; i++) begin
            r  = int'(red_in[i*8 +: 8]);
            g  = int'(green_in[i*8 +: 8]);
            b  = int'(blue_in[i*8 +: 8]);
            dr = (r > int'(red_exp))   ? r - int'(red_exp)   : int'(red_exp) - r;
            dg = (g > int'(green_exp)) ? g - int'(green_exp) : int'(green_exp) - g;
            db = (b > int'(blue_exp))  ? b - int'(blue_exp)  : int'(blue_exp) - b;
            if (dr <= int'(threshold) && dg <= int'(threshold) && db <= int'(threshold)) begin
                p_ro[i*8 +: 8] = desired_bg_r;
                p_go[i*8 +: 8] = desired_bg_g;
                p_bo[i*8 +: 8] = desired_bg_b;
            end else begin
                p_ro[i*8 +: 8] = r[7:0];
                p_go[i*8 +: 8] = g[7:0];
                p_bo[i*8 +: 8] = b[7:0];
            end
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("sum_onehot", $countones({Qsi, Qs, Qsd}), 1);
            chk("bg_onehot", $countones({Qbgi, Qbg, Qbgd}), 1);
            chk("qi", Qi, Qsi & Qbgi);
            if (!sum_busy) begin
                chk("red_sum", red_sum, m_rs);
                chk("green_sum", green_sum, m_gs);
                chk("blue_sum", blue_sum, m_bs);
            end
            if (!bg_busy) begin
                chk("red_out", red_out, m_ro);
                chk("green_out", green_out, m_go);
                chk("blue_out", blue_out, m_bo);
            end
        end
    end

    // Runs one phase from a negedge; checks latency, done hold and return to init.
    task automatic run_phase(input bit is_bg, input bit ack_val, input int hold, input bit poke_bg);
        int  cyc;
        bit  done;
        Ack = ack_val;
        if (is_bg) begin
            model_bg();
            bg_busy = 1'b1;
            Start_BgRemoval = 1'b1;
        end else begin
            model_sum();
            sum_busy = 1'b1;
            Start_Sum = 1'b1;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge Clk);
            cyc++;
            Start_Sum = 1'b0;
            if (is_bg) Start_BgRemoval = 1'b0;
            if (poke_bg && cyc == 2) Start_BgRemoval = 1'b1;
            if (poke_bg && cyc == 3) begin
                Start_BgRemoval = 1'b0;
                chk("bg_start_ignored", {Qbgi, Qbg}, 2'b10);
            end
            done = is_bg ? Qbgd : Qsd;
        end
        if (!done) begin
            chk(is_bg ? "bg_timeout" : "sum_timeout", 0, 1);
            sum_busy = 1'b0;
            bg_busy  = 1'b0;
            Ack = 1'b1;
            return;
        end
        chk(is_bg ? "bg_latency" : "sum_latency", cyc, N + 1);
        if (is_bg) begin
            m_ro = p_ro; m_go = p_go; m_bo = p_bo;
            bg_busy = 1'b0;
        end else begin
            m_rs = p_rs; m_gs = p_gs; m_bs = p_bs;
            sum_busy = 1'b0;
        end
        if (!ack_val) begin
            repeat (hold) begin
                @(negedge Clk);
                chk(is_bg ? "bgd_held" : "sd_held", is_bg ? Qbgd : Qsd, 1);
            end
            Ack = 1'b1;
        end
        @(negedge Clk);
        chk(is_bg ? "back_to_bgi" : "back_to_si", is_bg ? Qbgi : Qsi, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        Reset = 1'b1; Ack = 1'b1;
        Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
        red_exp = '0; green_exp = '0; blue_exp = '0; threshold = '0;
        desired_bg_r = '0; desired_bg_g = '0; desired_bg_b = '0;
        red_in = '0; green_in = '0; blue_in = '0;

        // Reset state
        repeat (5) @(negedge Clk);
        chk("rst_flags", {Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd}, 7'b1100100);
        chk("rst_sum", red_sum | green_sum | blue_sum, 0);
        chk("rst_out", red_out | green_out | blue_out, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Known average
        for (int i = 1; i < N; i++) set_pix(i, 8'd61, 8'd133, 8'd198);
        set_pix(0, 8'd204, 8'd0, 8'd0);
        run_phase(0, 1, 0, 0);
        chk("lit_red_sum", red_sum, 96);
        chk("lit_green_sum", green_sum, 99);
        chk("lit_blue_sum", blue_sum, 148);

        // Known removal
        red_exp = 8'd96; green_exp = 8'd99; blue_exp = 8'd148; threshold = 8'd60;
        desired_bg_r = 8'd106; desired_bg_g = 8'd168; desired_bg_b = 8'd79;
        run_phase(1, 1, 0, 0);
        chk("lit_red_out", red_out, 32'h6A6A6ACC);
        chk("lit_green_out", green_out, 32'hA8A8A800);
        chk("lit_blue_out", blue_out, 32'h4F4F4F00);

        // Threshold boundaries
        red_exp = 8'd100; green_exp = 8'd100; blue_exp = 8'd100;
        desired_bg_r = 8'd1; desired_bg_g = 8'd2; desired_bg_b = 8'd3;
        set_pix(0, 8'd100, 8'd100, 8'd100);
        set_pix(1, 8'd101, 8'd100, 8'd100);
        set_pix(2, 8'd0, 8'd0, 8'd0);
        set_pix(3, 8'd0, 8'd0, 8'd0);
        threshold = 8'd0;
        run_phase(1, 1, 0, 0);
        chk("th0_red", VW'(red_out[15:0]), 16'h6501);
        threshold = 8'd1;
        run_phase(1, 1, 0, 0);
        chk("th1_red", VW'(red_out[15:0]), 16'h0101);
        threshold = 8'd255;
        run_phase(1, 1, 0, 0);
        chk("th255_red", red_out, 32'h01010101);
        chk("th255_blue", blue_out, 32'h03030303);

        // Done held without Ack; bg start ignored during sum
        run_phase(0, 0, 8, 1);
        run_phase(1, 0, 8, 0);

        // Randomized runs, sometimes feeding the average back as expected colour
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++)
                set_pix(i, 8'($urandom), 8'($urandom), 8'($urandom));
            run_phase(0, 1, 0, 0);
            k = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 1) begin
                red_exp = m_rs[7:0]; green_exp = m_gs[7:0]; blue_exp = m_bs[7:0];
            end else begin
                red_exp   = red_in[k*8 +: 8]   ^ 8'($urandom_range(0, 7));
                green_exp = green_in[k*8 +: 8] ^ 8'($urandom_range(0, 7));
                blue_exp  = blue_in[k*8 +: 8]  ^ 8'($urandom_range(0, 7));
            end
            case ($urandom_range(0, 3))
                0:       threshold = 8'd0;
                1:       threshold = 8'd255;
                default: threshold = 8'($urandom_range(0, 100));
            endcase
            desired_bg_r = 8'($urandom); desired_bg_g = 8'($urandom); desired_bg_b = 8'($urandom);
            run_phase(1, 1, 0, 0);
        end

        // Reset during the second clock of removal
        threshold = 8'd255;
        bg_busy = 1'b1;
        Start_BgRemoval = 1'b1;
        @(negedge Clk);
        Start_BgRemoval = 1'b0;
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("abort_flags", {Qbgi, Qbg, Qbgd, Qsi}, 4'b1001);
        chk("abort_out", red_out | green_out | blue_out, 0);
        chk("abort_sum", red_sum | green_sum | blue_sum, 0);
        m_rs = '0; m_gs = '0; m_bs = '0;
        m_ro = '0; m_go = '0; m_bo = '0;
        bg_busy = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("post_abort_idle", Qi, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe.md
Name: pe

Overview:
- Background-removal processing element operating on a packed vector of NUM_PIXELS RGB pixels (8 bits per channel).
- Phase 1 (sum) computes the per-channel average colour of the input pixels; the host feeds this back as the expected background colour.
- Phase 2 (bg removal) replaces every pixel within a threshold of the expected colour with a desired background colour.
- Used as one of several parallel processors under a host controller; each phase has its own one-hot state flags.

Parameters:
- NUM_PIXELS, 4, number of pixels per vector. Must be a power of two ≥ 2, so averaging is a right shift.

Ports:
- Clk  in  1  clock, rising edge.
- Ack  in  1  host acknowledge; moves a done state back to its init state.
- Reset  in  1  asynchronous, active-high reset.
- red_exp, green_exp, blue_exp  in  8 each  expected background colour.
- threshold  in  8  per-channel match tolerance.
- desired_bg_r, desired_bg_g, desired_bg_b  in  8 each  replacement colour.
- Start_Sum  in  1  starts the sum phase.
- Start_BgRemoval  in  1  starts the background-removal phase.
- red_in, green_in, blue_in  in  8*NUM_PIXELS each  pixel i occupies bits [8i+7:8i].
- red_out, green_out, blue_out  out  8*NUM_PIXELS each  processed pixels, same packing.
- Qi  out  1  block idle (Qsi && Qbgi).
- Qbgi, Qbg, Qbgd  out  1 each  bg FSM init / working / done.
- Qsi, Qs, Qsd  out  1 each  sum FSM init / working / done.
- red_sum, green_sum, blue_sum  out  8*NUM_PIXELS each  per-channel average in bits [7:0]; upper bits are 0.

Behaviour:
- Reset (asynchronous): both FSMs go to init (Qsi=1, Qbgi=1, Qi=1, all other flags 0). All data outputs, accumulators and indices clear to 0.
- Sum FSM:
  - Qsi: if Start_Sum, go to Qs; clear the accumulators (8+log2(NUM_PIXELS) bits each) and set index=0.
  - Qs: each clock, add channel values of pixel[index] to the accumulators and increment index. After pixel NUM_PIXELS-1 is added, go to Qsd.
  - On entry to Qsd, register each sum >> log2(NUM_PIXELS) (truncating) into bits [7:0] of the *_sum output.
  - Qsd: stay until Ack=1, then go to Qsi.
  - Latency: Start_Sum sampled → Qsd asserted after NUM_PIXELS+1 clocks.
- Bg FSM:
  - Qbgi: if Start_BgRemoval and the sum FSM is not in Qs, go to Qbg with index=0. Start_BgRemoval while in Qs is ignored.
  - Qbg: one pixel per clock. A pixel matches when |r-red_exp| ≤ threshold AND |g-green_exp| ≤ threshold AND |b-blue_exp| ≤ threshold, using unsigned absolute difference.
    - Match: write desired_bg_* to the output slot for that pixel.
    - No match: copy the input pixel to the output slot.
  - After pixel NUM_PIXELS-1, go to Qbgd. Qbgd: stay until Ack=1, then go to Qbgi.
  - Latency: Start_BgRemoval sampled → Qbgd after NUM_PIXELS+1 clocks.
- The two FSMs are independent apart from the bg start interlock.
- Outputs hold their last values after leaving a done state until the next run of that phase overwrites them.
- With Ack held high, each done state lasts exactly one clock.
- Inputs are sampled live during Qs/Qbg; the host keeps them stable for the whole phase.
- Start pulses received while an FSM is not in its init state are ignored.
- Threshold boundary: difference == threshold counts as a match. threshold=0 matches only an exact colour; threshold=255 matches every pixel.
- Reset asserted mid-phase aborts immediately to init with outputs cleared.
- Flags are registered and exactly one-hot per FSM at all times.

Decomposition:
- Shared package: state encodings for both FSMs (init/work/done), CHANNEL_W=8, and an index-width function $clog2(NUM_PIXELS).
- One natural sub-module: pe_pixel_match, combinational. It takes one pixel, the expected colour, threshold and desired colour, and outputs the replaced or passed-through pixel.

Test Plan:
1. Reset held for 5 clocks: all outputs 0; Qi=Qsi=Qbgi=1; all other flags 0.
2. Pixels {3..0} = (61,133,198)×3 with (204,0,0) at pixel 0; pulse Start_Sum, Ack=1. Expect Qsd after 5 clocks, red_sum=96, green_sum=99, blue_sum=148, then Qsi on the next clock.
3. Same pixels, exp=(96,99,148), threshold=60, desired=(106,168,79); pulse Start_BgRemoval. Expect Qbgd; pixels 3..1 out=(106,168,79); pixel 0 out=(204,0,0).
4. Threshold boundary with exp=(100,100,100):
   - threshold=0, pixel (100,100,100) → replaced; pixel (101,100,100) → kept.
   - threshold=1 → (101,100,100) replaced.
5. Ack=0 held: Qsd/Qbgd remain asserted indefinitely. Start_BgRemoval pulsed during Qs is ignored (Qbgi stays 1).
6. Reset asserted at the 2nd clock of Qbg: Qbgi=1 asynchronously; red_out/green_out/blue_out=0.
